// File: rtl/rdma_stream_arb_if.sv
// Bundle of the per-source AXI-Stream inputs and the merged AXI-Stream output
// used by the RDMA stream arbiter. The arbiter takes the slave view; the
// environment (sources plus receive engine) takes the master view.
interface rdma_stream_arb_if #(
    parameter int NUM_SRC        = 4,
    parameter int AXI_DATA_WIDTH = 512
);
    logic [NUM_SRC*AXI_DATA_WIDTH-1:0]     S_AXIS_TDATA;
    logic [NUM_SRC*AXI_DATA_WIDTH/8-1:0]   S_AXIS_TKEEP;
    logic [NUM_SRC-1:0]                    S_AXIS_TLAST;
    logic [NUM_SRC-1:0]                    S_AXIS_TVALID;
    logic [NUM_SRC-1:0]                    S_AXIS_TREADY;

    logic [AXI_DATA_WIDTH-1:0]             M_AXIS_TDATA;
    logic [AXI_DATA_WIDTH/8-1:0]           M_AXIS_TKEEP;
    logic                                  M_AXIS_TLAST;
    logic                                  M_AXIS_TVALID;
    logic                                  M_AXIS_TREADY;

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
        output S_AXIS_TREADY,
        output M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
        input  M_AXIS_TREADY
    );

    modport master (
        output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
        input  S_AXIS_TREADY,
        input  M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/rdma_stream_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC RDMA packet streams onto
// the single stream feeding the RDMA receive engine. A grant lasts from the
// header beat through TLAST; new grants are throttled by an outstanding-write
// credit counter that is returned by B-channel handshakes.
// The interface instance must be built with the same NUM_SRC and
// AXI_DATA_WIDTH as this module.
module rdma_stream_arb #(
    parameter int AXI_DATA_WIDTH  = 512,
    parameter int NUM_SRC         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    rdma_stream_arb_if.slave                       bus,
    input  logic                                   B_HANDSHAKE,
    output logic [$clog2(NUM_SRC)-1:0]             GRANT,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   OUTSTANDING,
    output logic                                   ERR_UNDERFLOW
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int KW = AXI_DATA_WIDTH / 8;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] lastGrant_q, lastGrant_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          errUnderflow_q, errUnderflow_d;
    logic          firstBeat_q, firstBeat_d;

    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          anyValid;
    logic          creditOk;
    logic          inXfer;
    logic          beat;
    logic          headerBeat;
    logic          lastBeat;

    // Round-robin search: first valid source scanning upward from lastGrant+1 with wrap
    always_comb begin
        pick     = lastGrant_q;
        anyValid = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = GW'((int'(lastGrant_q) + i) % NUM_SRC);
            if (!anyValid && bus.S_AXIS_TVALID[idx]) begin
                pick     = idx;
                anyValid = 1'b1;
            end
        end
    end

    // Zero-latency pass-through of the granted source while a packet is in flight
    always_comb begin
        inXfer            = (state_q == ST_XFER);
        bus.M_AXIS_TDATA  = '0;
        bus.M_AXIS_TKEEP  = '0;
        bus.M_AXIS_TLAST  = 1'b0;
        bus.M_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TREADY = '0;
        if (inXfer) begin
            bus.M_AXIS_TDATA           = bus.S_AXIS_TDATA[grant_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            bus.M_AXIS_TKEEP           = bus.S_AXIS_TKEEP[grant_q*KW +: KW];
            bus.M_AXIS_TLAST           = bus.S_AXIS_TLAST[grant_q];
            bus.M_AXIS_TVALID          = bus.S_AXIS_TVALID[grant_q];
            bus.S_AXIS_TREADY[grant_q] = bus.M_AXIS_TREADY;
        end
        beat       = inXfer & bus.M_AXIS_TVALID & bus.M_AXIS_TREADY;
        headerBeat = beat & firstBeat_q;
        lastBeat   = beat & bus.M_AXIS_TLAST;
        creditOk   = (outstanding_q < OW'(MAX_OUTSTANDING));
    end

    // Packet FSM: grant in ARB when a credit is free, release on the TLAST beat
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        firstBeat_d = firstBeat_q;
        case (state_q)
            ST_ARB: begin
                if (creditOk && anyValid) begin
                    state_d     = ST_XFER;
                    grant_d     = pick;
                    firstBeat_d = 1'b1;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    firstBeat_d = 1'b0;
                end
                if (lastBeat) begin
                    state_d     = ST_ARB;
                    lastGrant_d = grant_q;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Credit counter: header beats take a credit, B handshakes return one
    always_comb begin
        outstanding_d  = outstanding_q;
        errUnderflow_d = errUnderflow_q;
        if (headerBeat && !B_HANDSHAKE) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (B_HANDSHAKE && !headerBeat) begin
            if (outstanding_q == '0) begin
                errUnderflow_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - 1'b1;
            end
        end
    end

    // State registers; source 0 gets first priority after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ARB;
            grant_q        <= '0;
            lastGrant_q    <= GW'(NUM_SRC - 1);
            outstanding_q  <= '0;
            errUnderflow_q <= 1'b0;
            firstBeat_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            lastGrant_q    <= lastGrant_d;
            outstanding_q  <= outstanding_d;
            errUnderflow_q <= errUnderflow_d;
            firstBeat_q    <= firstBeat_d;
        end
    end

    assign GRANT         = grant_q;
    assign OUTSTANDING   = outstanding_q;
    assign ERR_UNDERFLOW = errUnderflow_q;
endmodule

// File: tb/tb_rdma_stream_arb.sv
// Self-checking bench for rdma_stream_arb: random packet sources, random sink
// backpressure and B pulses, compared every cycle against a packet-level
// reference model of the arbitration and credit rules.
module tb_rdma_stream_arb;
    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int MAXO = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bHandshake = 1'b0;
    logic [1:0] grant;
    logic [1:0] outstanding;
    logic       errUnderflow;

    int checksDone   = 0;
    int checksPassed = 0;

    // Source driver state
    bit            srcValid[NS];
    logic [DW-1:0] srcData[NS];
    logic [KW-1:0] srcKeep[NS];
    bit            srcLast[NS];
    int            srcRemain[NS];
    int            pendLen[NS];

    // Stimulus policy knobs
    int autoMask, autoPct, autoMaxLen, autoFixedLen, readyPct, bMode, bPct;
    bit bOnce;
    bit curReady, curB, prevReady, prevB;
    bit prevHsk[NS];

    // Reference model state
    bit mBusy, mFirst, mErr;
    int mSrc, mLastG, mCredits, mBeat;

    rdma_stream_arb_if #(.NUM_SRC(NS), .AXI_DATA_WIDTH(DW)) bus();

    rdma_stream_arb #(
        .AXI_DATA_WIDTH(DW),
        .NUM_SRC(NS),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .B_HANDSHAKE(bHandshake),
        .GRANT(grant),
        .OUTSTANDING(outstanding),
        .ERR_UNDERFLOW(errUnderflow)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checksDone++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        else
            checksPassed++;
    endtask

    task automatic modelReset();
        mBusy = 0; mFirst = 0; mErr = 0;
        mSrc = 0; mLastG = NS - 1; mCredits = 0; mBeat = 0;
        prevReady = 0; prevB = 0; curReady = 0; curB = 0;
        for (int k = 0; k < NS; k++) begin
            prevHsk[k] = 0; srcValid[k] = 0; srcLast[k] = 0;
            srcData[k] = '0; srcKeep[k] = '0; srcRemain[k] = 0; pendLen[k] = 0;
        end
    endtask

    task automatic driveBus();
        bus.M_AXIS_TREADY = curReady;
        bHandshake = curB;
        for (int k = 0; k < NS; k++) begin
            bus.S_AXIS_TDATA[k*DW +: DW] = srcData[k];
            bus.S_AXIS_TKEEP[k*KW +: KW] = srcKeep[k];
            bus.S_AXIS_TLAST[k]  = srcLast[k];
            bus.S_AXIS_TVALID[k] = srcValid[k];
        end
    endtask

    // Advance the model across one rising edge using what was on the wires before it
    task automatic stepModel();
        bit xfer, hdr, anyV;
        int pick, idx;
        xfer = mBusy && srcValid[mSrc] && prevReady;
        hdr  = xfer && mFirst;
        anyV = 0; pick = 0;
        for (int i = 1; i <= NS; i++) begin
            idx = (mLastG + i) % NS;
            if (!anyV && srcValid[idx]) begin anyV = 1; pick = idx; end
        end
        if (!mBusy) begin
            if (mCredits < MAXO && anyV) begin
                mBusy = 1; mSrc = pick; mFirst = 1; mBeat = 0;
            end
        end else if (xfer) begin
            mFirst = 0; mBeat++;
            if (srcLast[mSrc]) begin mBusy = 0; mLastG = mSrc; end
        end
        if (hdr && !prevB) mCredits++;
        else if (prevB && !hdr) begin
            if (mCredits == 0) mErr = 1; else mCredits--;
        end
    endtask

    task automatic newBeat(input int k);
        srcData[k] = DW'($urandom);
        srcKeep[k] = KW'($urandom);
        srcLast[k] = (srcRemain[k] == 1);
    endtask

    task automatic advanceSources();
        int len;
        for (int k = 0; k < NS; k++) begin
            if (srcValid[k] && prevHsk[k]) begin
                if (srcLast[k]) srcValid[k] = 0;
                else begin srcRemain[k]--; newBeat(k); end
            end
            if (!srcValid[k]) begin
                len = 0;
                if (pendLen[k] > 0) begin len = pendLen[k]; pendLen[k] = 0; end
                else if (autoMask[k] && $urandom_range(99) < autoPct)
                    len = (autoFixedLen > 0) ? autoFixedLen : int'($urandom_range(autoMaxLen, 1));
                if (len > 0) begin srcValid[k] = 1; srcRemain[k] = len; newBeat(k); end
            end
        end
    endtask

    task automatic applyStimulus();
        stepModel();
        advanceSources();
        curReady = ($urandom_range(99) < readyPct);
        case (bMode)
            1: curB = (mCredits > 0) && ($urandom_range(99) < bPct);
            2: begin curB = bOnce; bOnce = 0; end
            3: curB = mBusy && mFirst && srcValid[mSrc] && curReady;
            default: curB = 0;
        endcase
        driveBus();
    endtask

    task automatic sampleAndCompare();
        logic [NS-1:0] eReady;
        eReady = (mBusy && curReady) ? NS'(1 << mSrc) : '0;
        checkOutput("m_tvalid", bus.M_AXIS_TVALID, mBusy ? srcValid[mSrc] : 1'b0);
        checkOutput("m_tdata",  bus.M_AXIS_TDATA,  mBusy ? srcData[mSrc] : '0);
        checkOutput("m_tkeep",  bus.M_AXIS_TKEEP,  mBusy ? srcKeep[mSrc] : '0);
        checkOutput("m_tlast",  bus.M_AXIS_TLAST,  mBusy ? srcLast[mSrc] : 1'b0);
        checkOutput("s_tready", bus.S_AXIS_TREADY, eReady);
        checkOutput("grant",    grant, mSrc);
        checkOutput("outstanding", outstanding, mCredits);
        checkOutput("err_underflow", errUnderflow, mErr);
        for (int k = 0; k < NS; k++) prevHsk[k] = srcValid[k] && bus.S_AXIS_TREADY[k];
        prevReady = curReady;
        prevB = curB;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            applyStimulus();
            @(negedge clk);
            sampleAndCompare();
        end
    endtask

    // Main sequence: reset, directed scenarios, random traffic, mid-packet reset
    initial begin
        bit found;
        autoMask = 0; autoPct = 0; autoMaxLen = 1; autoFixedLen = 0;
        readyPct = 100; bMode = 0; bPct = 0; bOnce = 0;
        modelReset();
        driveBus();
        repeat (2) @(negedge clk);
        sampleAndCompare();
        reset = 1'b0;

        // Sources 0 and 2 present 3-beat packets together
        pendLen[0] = 3; pendLen[2] = 3;
        runCycles(12);
        checkOutput("two_pkt_grant", grant, 2);
        checkOutput("two_pkt_credits", outstanding, 2);

        // Credits exhausted: source 1 stalls until one B pulse
        pendLen[1] = 2;
        runCycles(6);
        checkOutput("stall_tready", bus.S_AXIS_TREADY, 0);
        bMode = 2; bOnce = 1;
        runCycles(8);
        checkOutput("resume_grant", grant, 1);
        checkOutput("resume_credits", outstanding, 2);

        // All sources streaming header-only packets, credits returned eagerly
        bMode = 1; bPct = 100;
        autoMask = 4'hF; autoPct = 100; autoFixedLen = 1;
        runCycles(24);

        // Random traffic with backpressure and random B pulses
        autoPct = 30; autoFixedLen = 0; autoMaxLen = 6; readyPct = 60; bPct = 25;
        runCycles(300);
        autoMask = 0;
        runCycles(40);

        // Long 16-beat packet under random backpressure
        pendLen[3] = 16; readyPct = 50;
        runCycles(60);

        // Drain credits, then header coincident with B, then B at zero
        readyPct = 100; bPct = 100;
        runCycles(6);
        pendLen[1] = 1; bMode = 3;
        runCycles(4);
        checkOutput("coincident_credits", outstanding, 0);
        checkOutput("coincident_err", errUnderflow, 0);
        bMode = 2; bOnce = 1;
        runCycles(3);
        bMode = 0;
        runCycles(3);
        checkOutput("underflow_sticky", errUnderflow, 1);

        // Reset on beat 2 of a 5-beat packet
        pendLen[3] = 5;
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            runCycles(1);
            if (mBusy && mBeat == 1) found = 1;
        end
        checkOutput("rst_wait", found, 1);
        reset = 1'b1;
        #1;
        checkOutput("rst_m_tvalid", bus.M_AXIS_TVALID, 0);
        checkOutput("rst_m_tdata", bus.M_AXIS_TDATA, 0);
        checkOutput("rst_m_tlast", bus.M_AXIS_TLAST, 0);
        checkOutput("rst_s_tready", bus.S_AXIS_TREADY, 0);
        checkOutput("rst_credits", outstanding, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_err", errUnderflow, 0);
        modelReset();
        driveBus();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pendLen[0] = 2; pendLen[3] = 2;
        runCycles(12);
        checkOutput("post_rst_grant", grant, 3);
        checkOutput("post_rst_credits", outstanding, 2);

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end
endmodule
